// File: rtl/ttt_pkg.sv
// Shared tic-tac-toe types: cell encoding, turn states, win-line table.
package ttt_pkg;

    localparam int NUM_CELLS = 9;

    typedef logic [1:0] cell_t;
    typedef cell_t [NUM_CELLS-1:0] board_t;
    typedef logic [3:0] idx_t;

    localparam cell_t CELL_EMPTY  = 2'b00;
    localparam cell_t CELL_PLAYER = 2'b01;
    localparam cell_t CELL_COMP   = 2'b10;

    typedef enum logic [1:0] {
        P_TURN = 2'd0,
        C_TURN = 2'd1,
        DONE   = 2'd2
    } state_t;

    localparam idx_t WIN_LINES [8][3] = '{
        '{4'd0, 4'd1, 4'd2},
        '{4'd3, 4'd4, 4'd5},
        '{4'd6, 4'd7, 4'd8},
        '{4'd0, 4'd3, 4'd6},
        '{4'd1, 4'd4, 4'd7},
        '{4'd2, 4'd5, 4'd8},
        '{4'd0, 4'd4, 4'd8},
        '{4'd2, 4'd4, 4'd6}
    };

    function automatic logic has_line(board_t b, cell_t side);
        logic hit;
        hit = 1'b0;
        for (int l = 0; l < 8; l++) begin
            if (b[WIN_LINES[l][0]] == side &&
                b[WIN_LINES[l][1]] == side &&
                b[WIN_LINES[l][2]] == side)
                hit = 1'b1;
        end
        return hit;
    endfunction

endpackage

// File: rtl/move_decode.sv
// Decodes one side's enable bus into a target cell and its legality bits.
module move_decode
    import ttt_pkg::*;
#(
    parameter bit STRICT_ONEHOT = 1'b1
) (
    input  logic [8:0] enable,
    input  board_t     cells,
    output logic       onehot_ok,
    output idx_t       target,
    output logic       cell_free
);

    assign onehot_ok = STRICT_ONEHOT ? $onehot(enable) : |enable;

    // lowest set bit wins when several are set
    always_comb begin
        target = '0;
        for (int i = NUM_CELLS - 1; i >= 0; i--) begin
            if (enable[i])
                target = idx_t'(i);
        end
    end

    assign cell_free = (cells[target] == CELL_EMPTY);

endmodule

// File: rtl/board_store.sv
// Tic-tac-toe board owner: commits legal moves, tracks turn and count.
// Optional win detection when BOARD_STORE_WIN_DETECT_EN is defined.
module board_store
    import ttt_pkg::*;
#(
    parameter bit FIRST_MOVER   = 1'b0,
    parameter bit STRICT_ONEHOT = 1'b1
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       clear,
    input  logic [8:0] p_enable,
    input  logic [8:0] c_enable,
    output logic [1:0] pos1,
    output logic [1:0] pos2,
    output logic [1:0] pos3,
    output logic [1:0] pos4,
    output logic [1:0] pos5,
    output logic [1:0] pos6,
    output logic [1:0] pos7,
    output logic [1:0] pos8,
    output logic [1:0] pos9,
    output logic       turn,
    output logic [3:0] move_count,
    output logic       wrong_move,
    output logic       board_full,
    output logic       game_over,
    output logic [1:0] winner
);

    localparam state_t FIRST_STATE = FIRST_MOVER ? C_TURN : P_TURN;

    state_t     state_q, state_d;
    board_t     board_q, board_d;
    logic [3:0] count_q, count_d;
    logic       wrong_q, wrong_d;

    logic p_ok, p_free, c_ok, c_free;
    idx_t p_tgt, c_tgt;

    move_decode #(.STRICT_ONEHOT(STRICT_ONEHOT)) u_p_dec (
        .enable    (p_enable),
        .cells     (board_q),
        .onehot_ok (p_ok),
        .target    (p_tgt),
        .cell_free (p_free)
    );

    move_decode #(.STRICT_ONEHOT(STRICT_ONEHOT)) u_c_dec (
        .enable    (c_enable),
        .cells     (board_q),
        .onehot_ok (c_ok),
        .target    (c_tgt),
        .cell_free (c_free)
    );

    logic p_req, c_req, is_c;
    logic on_req, off_req, on_ok, on_free;
    idx_t on_tgt;
    cell_t mover;

    assign p_req   = |p_enable;
    assign c_req   = |c_enable;
    assign is_c    = (state_q == C_TURN);
    assign on_req  = is_c ? c_req : p_req;
    assign off_req = is_c ? p_req : c_req;
    assign on_ok   = is_c ? c_ok : p_ok;
    assign on_free = is_c ? c_free : p_free;
    assign on_tgt  = is_c ? c_tgt : p_tgt;
    assign mover   = is_c ? CELL_COMP : CELL_PLAYER;

`ifdef BOARD_STORE_WIN_DETECT_EN
    cell_t winner_q, winner_d;
`endif

    always_comb begin
        state_d = state_q;
        board_d = board_q;
        count_d = count_q;
        wrong_d = 1'b0;
`ifdef BOARD_STORE_WIN_DETECT_EN
        winner_d = winner_q;
`endif
        if (clear) begin
            state_d = FIRST_STATE;
            board_d = '0;
            count_d = '0;
`ifdef BOARD_STORE_WIN_DETECT_EN
            winner_d = CELL_EMPTY;
`endif
        end else if (p_req || c_req) begin
            if (state_q != DONE && !off_req && on_req && on_ok && on_free) begin
                board_d[on_tgt] = mover;
                count_d = (count_q == 4'd9) ? count_q : count_q + 4'd1;
                state_d = is_c ? P_TURN : C_TURN;
                if (count_d == 4'd9)
                    state_d = DONE;
`ifdef BOARD_STORE_WIN_DETECT_EN
                // judged on the post-commit board so the win lands with the move
                if (has_line(board_d, mover)) begin
                    winner_d = mover;
                    state_d  = DONE;
                end
`endif
            end else begin
                wrong_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= FIRST_STATE;
            board_q <= '0;
            count_q <= '0;
            wrong_q <= 1'b0;
`ifdef BOARD_STORE_WIN_DETECT_EN
            winner_q <= CELL_EMPTY;
`endif
        end else begin
            state_q <= state_d;
            board_q <= board_d;
            count_q <= count_d;
            wrong_q <= wrong_d;
`ifdef BOARD_STORE_WIN_DETECT_EN
            winner_q <= winner_d;
`endif
        end
    end

`ifdef BOARD_STORE_WIN_DETECT_EN
    assign winner = winner_q;
`else
    assign winner = CELL_EMPTY;
`endif

    assign pos1 = board_q[0];
    assign pos2 = board_q[1];
    assign pos3 = board_q[2];
    assign pos4 = board_q[3];
    assign pos5 = board_q[4];
    assign pos6 = board_q[5];
    assign pos7 = board_q[6];
    assign pos8 = board_q[7];
    assign pos9 = board_q[8];

    assign turn       = (state_q == C_TURN);
    assign move_count = count_q;
    assign wrong_move = wrong_q;
    assign board_full = (count_q == 4'd9);
    assign game_over  = (state_q == DONE);

endmodule

// File: tb/tb_board_store.sv
// Bench for board_store: strict and loose one-hot instances against a game model.
module tb_board_store;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       clear = 1'b0;
    logic [8:0] p_enable = '0;
    logic [8:0] c_enable = '0;

    logic [1:0][8:0][1:0] bd;
    logic [1:0]           tn;
    logic [1:0][3:0]      mc;
    logic [1:0]           wm;
    logic [1:0]           bf;
    logic [1:0]           go;
    logic [1:0][1:0]      wn;

    int vectors = 0;
    int miscompares = 0;

    always #5 clock = ~clock;

    board_store #(.FIRST_MOVER(1'b0), .STRICT_ONEHOT(1'b1)) dut_s (
        .clock(clock), .reset(reset), .clear(clear),
        .p_enable(p_enable), .c_enable(c_enable),
        .pos1(bd[0][0]), .pos2(bd[0][1]), .pos3(bd[0][2]),
        .pos4(bd[0][3]), .pos5(bd[0][4]), .pos6(bd[0][5]),
        .pos7(bd[0][6]), .pos8(bd[0][7]), .pos9(bd[0][8]),
        .turn(tn[0]), .move_count(mc[0]), .wrong_move(wm[0]),
        .board_full(bf[0]), .game_over(go[0]), .winner(wn[0])
    );

    board_store #(.FIRST_MOVER(1'b0), .STRICT_ONEHOT(1'b0)) dut_l (
        .clock(clock), .reset(reset), .clear(clear),
        .p_enable(p_enable), .c_enable(c_enable),
        .pos1(bd[1][0]), .pos2(bd[1][1]), .pos3(bd[1][2]),
        .pos4(bd[1][3]), .pos5(bd[1][4]), .pos6(bd[1][5]),
        .pos7(bd[1][6]), .pos8(bd[1][7]), .pos9(bd[1][8]),
        .turn(tn[1]), .move_count(mc[1]), .wrong_move(wm[1]),
        .board_full(bf[1]), .game_over(go[1]), .winner(wn[1])
    );

    // game model: k = 0 strict instance, k = 1 loose instance
    int mb [2][9];
    int mcnt [2];
    int mturn [2];
    int mdone [2];
    int mwrong [2];
    int mwin [2];

    function automatic int lowbit(logic [8:0] v);
        for (int i = 0; i < 9; i++)
            if (v[i]) return i;
        return -1;
    endfunction

    function automatic bit three(int k, int who, int a, int b, int c);
        return mb[k][a] == who && mb[k][b] == who && mb[k][c] == who;
    endfunction

    function automatic bit won(int k, int who);
        return three(k, who, 0, 1, 2) || three(k, who, 3, 4, 5) ||
               three(k, who, 6, 7, 8) || three(k, who, 0, 3, 6) ||
               three(k, who, 1, 4, 7) || three(k, who, 2, 5, 8) ||
               three(k, who, 0, 4, 8) || three(k, who, 2, 4, 6);
    endfunction

    task automatic m_init(int k);
        for (int i = 0; i < 9; i++) mb[k][i] = 0;
        mcnt[k] = 0; mturn[k] = 0; mdone[k] = 0;
        mwrong[k] = 0; mwin[k] = 0;
    endtask

    task automatic m_step(int k);
        logic [8:0] on, off;
        int idx, who;
        bit legal;
        mwrong[k] = 0;
        if (clear) begin
            m_init(k);
        end else if (p_enable != 0 || c_enable != 0) begin
            on  = mturn[k] ? c_enable : p_enable;
            off = mturn[k] ? p_enable : c_enable;
            idx = lowbit(on);
            legal = !mdone[k] && off == 0 && on != 0 &&
                    (k == 1 || $countones(on) == 1) && mb[k][idx] == 0;
            if (!legal) begin
                mwrong[k] = 1;
            end else begin
                who = mturn[k] ? 2 : 1;
                mb[k][idx] = who;
                mcnt[k]++;
                mturn[k] = 1 - mturn[k];
`ifdef BOARD_STORE_WIN_DETECT_EN
                if (won(k, who)) begin
                    mwin[k] = who;
                    mdone[k] = 1;
                end
`endif
                if (mcnt[k] == 9) mdone[k] = 1;
            end
        end
    endtask

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            m_init(0);
            m_init(1);
        end else begin
            m_step(0);
            m_step(1);
        end
    end

    task automatic chk(string nm, logic [31:0] got, logic [31:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", nm, got, want);
        end
    endtask

    always @(negedge clock) begin
        if (!reset) begin
            for (int k = 0; k < 2; k++) begin
                for (int i = 0; i < 9; i++)
                    chk($sformatf("dut%0d pos%0d", k, i + 1),
                        32'(bd[k][i]), 32'(mb[k][i]));
                chk($sformatf("dut%0d move_count", k), 32'(mc[k]), 32'(mcnt[k]));
                chk($sformatf("dut%0d wrong_move", k), 32'(wm[k]), 32'(mwrong[k]));
                chk($sformatf("dut%0d board_full", k), 32'(bf[k]), 32'(mcnt[k] == 9));
                chk($sformatf("dut%0d game_over", k), 32'(go[k]), 32'(mdone[k]));
                chk($sformatf("dut%0d winner", k), 32'(wn[k]), 32'(mwin[k]));
                if (!mdone[k])
                    chk($sformatf("dut%0d turn", k), 32'(tn[k]), 32'(mturn[k]));
            end
        end
    end

    task automatic apply(logic [8:0] p, logic [8:0] c, logic cl);
        @(negedge clock);
        p_enable = p;
        c_enable = c;
        clear    = cl;
        @(negedge clock);
        p_enable = '0;
        c_enable = '0;
        clear    = 1'b0;
    endtask

    initial begin
        repeat (2) @(negedge clock);
        reset = 1'b0;
        chk("reset pos1", 32'(bd[0][0]), 32'd0);
        chk("reset count", 32'(mc[0]), 32'd0);
        chk("reset turn", 32'(tn[0]), 32'd0);

        apply(9'h001, 9'h000, 1'b0);
        chk("p1 pos1", 32'(bd[0][0]), 32'd1);
        chk("p1 turn", 32'(tn[0]), 32'd1);
        chk("p1 count", 32'(mc[0]), 32'd1);
        chk("p1 wrong", 32'(wm[0]), 32'd0);

        apply(9'h000, 9'h001, 1'b0);
        chk("occupied wrong", 32'(wm[0]), 32'd1);
        chk("occupied turn", 32'(tn[0]), 32'd1);
        chk("occupied count", 32'(mc[0]), 32'd1);
        apply(9'h000, 9'h000, 1'b0);
        chk("wrong pulse ends", 32'(wm[0]), 32'd0);

        apply(9'h000, 9'h000, 1'b1);
        apply(9'h003, 9'h000, 1'b0);
        chk("strict 003 wrong", 32'(wm[0]), 32'd1);
        chk("strict 003 pos1", 32'(bd[0][0]), 32'd0);
        chk("loose 003 pos1", 32'(bd[1][0]), 32'd1);
        chk("loose 003 wrong", 32'(wm[1]), 32'd0);

        apply(9'h000, 9'h000, 1'b1);
        apply(9'h010, 9'h020, 1'b0);
        chk("both wrong", 32'(wm[0]), 32'd1);
        chk("both pos5", 32'(bd[0][4]), 32'd0);
        chk("both pos6", 32'(bd[0][5]), 32'd0);

        // draw: X O X / X O O / O X X
        apply(9'h001, 9'h000, 1'b0);
        apply(9'h000, 9'h002, 1'b0);
        apply(9'h004, 9'h000, 1'b0);
        apply(9'h000, 9'h010, 1'b0);
        apply(9'h008, 9'h000, 1'b0);
        apply(9'h000, 9'h020, 1'b0);
        apply(9'h080, 9'h000, 1'b0);
        apply(9'h000, 9'h040, 1'b0);
        apply(9'h100, 9'h000, 1'b0);
        chk("full board_full", 32'(bf[0]), 32'd1);
        chk("full game_over", 32'(go[0]), 32'd1);
        chk("full count", 32'(mc[0]), 32'd9);
        chk("full winner", 32'(wn[0]), 32'd0);
        chk("full pos7", 32'(bd[0][6]), 32'd2);
        apply(9'h001, 9'h000, 1'b0);
        chk("done wrong", 32'(wm[0]), 32'd1);
        chk("done count", 32'(mc[0]), 32'd9);
        apply(9'h000, 9'h000, 1'b1);
        chk("clear pos1", 32'(bd[0][0]), 32'd0);
        chk("clear pos9", 32'(bd[0][8]), 32'd0);
        chk("clear count", 32'(mc[0]), 32'd0);
        chk("clear turn", 32'(tn[0]), 32'd0);
        chk("clear game_over", 32'(go[0]), 32'd0);

        @(negedge clock);
        p_enable = 9'h001;
        @(negedge clock);
        chk("held first count", 32'(mc[0]), 32'd1);
        chk("held first wrong", 32'(wm[0]), 32'd0);
        @(negedge clock);
        p_enable = '0;
        chk("held second wrong", 32'(wm[0]), 32'd1);
        chk("held second count", 32'(mc[0]), 32'd1);
        apply(9'h000, 9'h000, 1'b1);

        apply(9'h001, 9'h000, 1'b0);
        apply(9'h000, 9'h008, 1'b0);
        apply(9'h002, 9'h000, 1'b0);
        apply(9'h000, 9'h010, 1'b0);
        apply(9'h004, 9'h000, 1'b0);
        chk("row pos3", 32'(bd[0][2]), 32'd1);
`ifdef BOARD_STORE_WIN_DETECT_EN
        chk("row winner", 32'(wn[0]), 32'd1);
        chk("row game_over", 32'(go[0]), 32'd1);
`else
        chk("row winner", 32'(wn[0]), 32'd0);
        chk("row game_over", 32'(go[0]), 32'd0);
`endif
        chk("row count", 32'(mc[0]), 32'd5);
        apply(9'h000, 9'h000, 1'b1);

        apply(9'h001, 9'h000, 1'b0);
        apply(9'h000, 9'h010, 1'b0);
        #2 reset = 1'b1;
        #1;
        chk("async pos1", 32'(bd[0][0]), 32'd0);
        chk("async pos5", 32'(bd[0][4]), 32'd0);
        chk("async count", 32'(mc[0]), 32'd0);
        chk("async turn", 32'(tn[0]), 32'd0);
        @(negedge clock);
        reset = 1'b0;
        apply(9'h100, 9'h000, 1'b0);
        chk("after reset pos9", 32'(bd[0][8]), 32'd1);
        chk("after reset turn", 32'(tn[0]), 32'd1);

        repeat (2) @(negedge clock);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/board_store.md
Name: board_store

Overview:
- Sequential owner of the 3x3 tic-tac-toe board; the writer whose outputs feed the wrong-move checker.
- Accepts one-hot move requests from the player (p_enable) and the computer (c_enable).
- Commits only legal moves into the nine 2-bit cell registers.
- Tracks whose turn it is, counts moves, flags rejected moves, and signals game over.

Parameters:
- FIRST_MOVER, 0, side that moves first after reset or clear: 0 = player, 1 = computer.
- STRICT_ONEHOT, 1, when 1 a request with more than one enable bit set is rejected; when 0 only the lowest set bit is used.

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- clear  input  1  synchronous new-game request; empties the board.
- p_enable  input  9  player move request, one-hot; bit i = cell i+1.
- c_enable  input  9  computer move request, one-hot; bit i = cell i+1.
- pos1..pos9  output  2 each  registered cell contents: 00 empty, 01 player, 10 computer; 11 never driven.
- turn  output  1  0 = player to move, 1 = computer to move.
- move_count  output  4  number of committed moves, 0..9.
- wrong_move  output  1  registered one-cycle pulse when a request is rejected.
- board_full  output  1  high when move_count == 9.
- game_over  output  1  high in state DONE.
- winner  output  2  00 none, 01 player, 10 computer.

Behaviour:
- Reset (async, active-high):
  - all pos = 00, move_count = 0, wrong_move = 0, winner = 00.
  - state = P_TURN if FIRST_MOVER = 0, else C_TURN; turn follows the state.
- States:
  - P_TURN: only p_enable is evaluated.
  - C_TURN: only c_enable is evaluated.
  - DONE: no moves accepted.
- Request: an enable bus is a request in any cycle where it is nonzero. Enables are sampled on the rising edge.
- Legal move (in P_TURN or C_TURN), all of:
  - the off-turn bus is zero;
  - the on-turn bus is one-hot (or nonzero when STRICT_ONEHOT = 0);
  - the target cell is 00.
- Commit (on the edge that samples a legal move):
  - cell written to 01 (player) or 10 (computer);
  - move_count increments;
  - state toggles P_TURN <-> C_TURN.
  - New values are visible one cycle after the request edge (latency 1).
- Rejection: any of the following causes no board, count or turn change and sets wrong_move = 1 for exactly the next cycle:
  - occupied cell;
  - non-one-hot request under STRICT_ONEHOT = 1;
  - off-turn bus nonzero;
  - any request while in DONE.
- Both buses nonzero in the same cycle: always rejected, even if the on-turn request alone is legal.
- A held request is re-evaluated every cycle. After a commit the cell is occupied, so a held request yields wrong_move on the following cycle; requesters must pulse their enables.
- Full board: the 9th commit moves the state to DONE and sets board_full = 1. move_count saturates at 9.
- clear:
  - overrides any request in the same cycle;
  - next cycle: board empty, move_count = 0, winner = 00, wrong_move = 0, state = FIRST_MOVER turn.
  - clear in DONE restarts the game.
- reset asserted mid-game: immediate return to the reset values listed above, regardless of state.

Optional Feature:
- Macro: BOARD_STORE_WIN_DETECT_EN.
- Defined:
  - after each commit, the 8 lines (3 rows, 3 columns, 2 diagonals) are checked against the post-commit board, combinationally from the next-state cell values;
  - a three-in-a-row for the mover sets winner to 01/10 and moves the state to DONE in the same cycle as the commit;
  - a win on the 9th move reports the winner with board_full = 1.
- Undefined: winner is tied to 00 and DONE is reached only on a full board.

Decomposition:
- Shared package ttt_pkg:
  - cell encoding constants CELL_EMPTY, CELL_PLAYER, CELL_COMP;
  - state enum P_TURN / C_TURN / DONE;
  - 8-entry win-line table of cell index triples;
  - constant NUM_CELLS = 9.
- One natural sub-module, move_decode (combinational):
  - inputs: enable bus and the 9 cell values;
  - outputs: onehot_ok, target index, cell_free.
  - Instantiated twice, once per side.

Test Plan:
- Reset, FIRST_MOVER = 0; p_enable = 9'h001 for one cycle -> next cycle pos1 = 01, turn = 1, move_count = 1, wrong_move = 0.
- After that move, c_enable = 9'h001 -> wrong_move pulses one cycle; pos1 stays 01, turn stays 1, move_count stays 1.
- In P_TURN, p_enable = 9'h003 -> wrong_move = 1, board unchanged. Repeat with STRICT_ONEHOT = 0 -> pos1 = 01 committed.
- In P_TURN, p_enable = 9'h010 and c_enable = 9'h020 in the same cycle -> rejected, wrong_move = 1, pos5 and pos6 stay 00.
- Play 9 legal alternating moves with no line -> board_full = 1, game_over = 1, move_count = 9, winner = 00. Then a further request -> wrong_move = 1. Then clear -> all pos = 00, move_count = 0, turn = FIRST_MOVER.
- With BOARD_STORE_WIN_DETECT_EN, player takes cells 1, 2, 3 (computer takes 4, 5) -> on the commit of cell 3, winner = 01 and game_over = 1 next cycle. Asserting reset mid-game clears everything asynchronously.
